memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes that stage's registered ALU result, store data, destination register and memory/write-back controls. It performs word loads and stores against an internal data memory with a configurable multi-cycle access latency, stalls upstream while an access is in flight, and registers results into the MEM/WB boundary for the write-back stage.

## Interface
- DEPTH, 256: data memory size in 32-bit words; power of two, at least 4.
- MEM_LAT, 2: cycles per memory access, counting the accept cycle; at least 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- valid_in  in  1  EX/MEM holds a valid instruction.
- Alu_Res  in  32  ALU result; also the byte address for loads and stores.
- D  in  32  store data (Op2 as registered by execute).
- Rd2  in  5  destination register.
- mem_R, mem_W, WB, RegW  in  1 each  load, store, write-back select and register-write controls.
- stall  out  1  upstream must hold all inputs and must not advance.
- valid_out  out  1  MEM/WB holds a valid instruction.
- alu_res_out  out  32  registered Alu_Res.
- mem_data_out  out  32  registered load data; 0 for non-loads.
- Rd3  out  5  registered Rd2.
- WB_out, RegW_out  out  1 each  registered controls.
- misaligned  out  1  one-cycle pulse for a load or store with Alu_Res[1:0] != 0.

## Operation
- Word index = Alu_Res[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- An access is requested when valid_in=1, (mem_R or mem_W)=1 and Alu_Res[1:0]=0.
- If mem_R and mem_W are both high, the instruction is a store only and mem_data_out=0.
- Misaligned access: memory is not touched and there is no stall. The instruction retires with valid_out=1, RegW_out=0 and misaligned=1.
- Non-memory instruction (valid_in=1, no mem_R or mem_W): passes through in 1 cycle with mem_data_out=0.
- FSM states: IDLE and BUSY. A 32-bit-safe counter cnt of width clog2(MEM_LAT) or greater runs in BUSY.
  - IDLE, access requested, MEM_LAT=1: the access completes at this edge and the state stays IDLE.
  - IDLE, access requested, MEM_LAT>1: latch address, data and controls internally; go to BUSY with cnt=1.
  - BUSY, cnt<MEM_LAT-1: cnt increments.
  - BUSY, cnt=MEM_LAT-1: the access completes at this edge; return to IDLE with cnt=0.
- Completion edge:
  - A store writes mem[index]=D.
  - A load registers mem_data_out=mem[index].
  - All MEM/WB outputs load, and valid_out=1.
- stall = (IDLE and request and MEM_LAT>1) or (BUSY and cnt<MEM_LAT-1). stall is combinational and is forced 0 while rst=1.
- While the stage is stalling, the MEM/WB registers load a bubble: valid_out=0, RegW_out=0, WB_out=0.
- valid_in=0 loads a bubble into MEM/WB.
- Memory array has no reset; its contents persist across rst.

## Timing
- Reset values: valid_out=0, alu_res_out=0, mem_data_out=0, Rd3=0, WB_out=0, RegW_out=0, misaligned=0. State is IDLE and cnt=0.
- Latency from input to MEM/WB outputs:
  - 1 cycle for non-memory or misaligned instructions.
  - MEM_LAT cycles for loads and stores.
- stall is high for exactly MEM_LAT-1 consecutive cycles per aligned access, starting in the accept cycle.
- Back-to-back accesses: the next access may be accepted in the cycle after completion. There is no idle gap.
- A store followed by a load to the same word returns the stored value, because the write commits before the load is accepted.
- Reset mid-access (rst=1 in BUSY): the pending store is aborted and no write occurs. The FSM returns to IDLE and all outputs take their reset values on that edge.

## Test plan
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0 and stall=0.
- Store then load with MEM_LAT=2:
  - Stimulus: SW Alu_Res=0x10, D=0xDEADBEEF, then LW Alu_Res=0x10, Rd2=5, RegW=1, WB=1.
  - Required response: stall high for 1 cycle per access; the LW retires with mem_data_out=0xDEADBEEF, Rd3=5 and RegW_out=1.
- Three back-to-back ALU instructions with Alu_Res=1, 2, 3 -> valid_out=1 on 3 consecutive cycles with alu_res_out=1, 2, 3; stall never rises.
- Misaligned LW at 0x13 -> no stall; misaligned=1 for one cycle with RegW_out=0; a following LW at 0x10 still returns 0xDEADBEEF.
- Reset during an in-flight store:
  - Setup: SW 0x20 with D=0xAAAA5555 completes.
  - Then issue SW 0x20 with D=0x12345678 and assert rst during BUSY, using MEM_LAT=3.
  - Required response: a subsequent LW 0x20 returns 0xAAAA5555.
- Address wrap with DEPTH=256: SW 0x400 with D=0x0000CAFE, then LW 0x000 -> mem_data_out=0x0000CAFE.

Source files
------------

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: EX/MEM input and MEM/WB output bundle of the memory stage.
//   master : upstream side; drives the instruction fields, observes stall and MEM/WB.
//   slave  : memory stage; consumes the instruction fields, drives stall and MEM/WB.
// Signals:
//   valid_in, Alu_Res, D, Rd2, mem_R, mem_W, WB, RegW : registered execute-stage outputs
//   stall                                             : upstream must hold and not advance
//   valid_out, alu_res_out, mem_data_out, Rd3,
//   WB_out, RegW_out, misaligned                      : MEM/WB register outputs
interface memory_cycle_if;
  logic        valid_in;
  logic [31:0] Alu_Res;
  logic [31:0] D;
  logic [4:0]  Rd2;
  logic        mem_R;
  logic        mem_W;
  logic        WB;
  logic        RegW;

  logic        stall;
  logic        valid_out;
  logic [31:0] alu_res_out;
  logic [31:0] mem_data_out;
  logic [4:0]  Rd3;
  logic        WB_out;
  logic        RegW_out;
  logic        misaligned;

  modport master (
    output valid_in, Alu_Res, D, Rd2, mem_R, mem_W, WB, RegW,
    input  stall, valid_out, alu_res_out, mem_data_out, Rd3, WB_out, RegW_out, misaligned
  );

  modport slave (
    input  valid_in, Alu_Res, D, Rd2, mem_R, mem_W, WB, RegW,
    output stall, valid_out, alu_res_out, mem_data_out, Rd3, WB_out, RegW_out, misaligned
  );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle: memory stage of the five-stage pipeline. Performs word loads/stores
// against an internal DEPTH-word data memory with MEM_LAT cycles per access, stalls
// upstream while an access is in flight and registers results into MEM/WB.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : memory_cycle_if.slave, EX/MEM inputs in, stall and MEM/WB outputs out
module memory_cycle #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  memory_cycle_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Access held while BUSY
  logic [31:0] addr_q, data_q;
  logic [4:0]  rd_q;
  logic        rd_en_q, wr_en_q, wb_q, regw_q;

  // MEM/WB registers
  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdata_q, mdata_d;
  logic [4:0]  rd3_q, rd3_d;
  logic        wbo_q, wbo_d;
  logic        regwo_q, regwo_d;
  logic        mis_q, mis_d;

  logic [31:0] mem [DEPTH];

  logic mem_op, req, latch_en, complete, stall_raw;

  assign mem_op = bus.valid_in && (bus.mem_R || bus.mem_W);
  assign req    = mem_op && (bus.Alu_Res[1:0] == 2'b00);

  // Completing access: the latched copy when finishing from BUSY, live inputs when
  // MEM_LAT is 1 and the access finishes in its accept cycle.
  logic          busy;
  logic [31:0]   c_addr, c_data;
  logic [4:0]    c_rd;
  logic          c_r, c_w, c_wb, c_regw;
  logic [AW-1:0] c_idx;

  assign busy   = (state_q == StBusy);
  assign c_addr = busy ? addr_q  : bus.Alu_Res;
  assign c_data = busy ? data_q  : bus.D;
  assign c_rd   = busy ? rd_q    : bus.Rd2;
  assign c_r    = busy ? rd_en_q : bus.mem_R;
  assign c_w    = busy ? wr_en_q : bus.mem_W;
  assign c_wb   = busy ? wb_q    : bus.WB;
  assign c_regw = busy ? regw_q  : bus.RegW;
  assign c_idx  = c_addr[AW+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    complete  = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (MEM_LAT == 1) begin
            complete = 1'b1;
          end else begin
            latch_en  = 1'b1;
            stall_raw = 1'b1;
            state_d   = StBusy;
            cnt_d     = CntW'(1);
          end
        end
      end
      StBusy: begin
        if (cnt_q < LastCnt) begin
          cnt_d     = cnt_q + CntW'(1);
          stall_raw = 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    rd3_d   = rd3_q;
    wbo_d   = wbo_q;
    regwo_d = regwo_q;
    mis_d   = mis_q;
    if (complete) begin
      valid_d = 1'b1;
      alu_d   = c_addr;
      // Read and write together is a store only.
      mdata_d = (c_r && !c_w) ? mem[c_idx] : 32'h0;
      rd3_d   = c_rd;
      wbo_d   = c_wb;
      regwo_d = c_regw;
      mis_d   = 1'b0;
    end else if (stall_raw || !bus.valid_in) begin
      valid_d = 1'b0;
      wbo_d   = 1'b0;
      regwo_d = 1'b0;
      mis_d   = 1'b0;
      mdata_d = 32'h0;
    end else begin
      // Not an accepted access: either non-memory, or a memory op with a bad address.
      valid_d = 1'b1;
      alu_d   = bus.Alu_Res;
      mdata_d = 32'h0;
      rd3_d   = bus.Rd2;
      wbo_d   = bus.WB;
      regwo_d = bus.RegW && !mem_op;
      mis_d   = mem_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      alu_q   <= '0;
      mdata_q <= '0;
      rd3_q   <= '0;
      wbo_q   <= 1'b0;
      regwo_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      rd3_q   <= rd3_d;
      wbo_q   <= wbo_d;
      regwo_q <= regwo_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wb_q    <= 1'b0;
      regw_q  <= 1'b0;
    end else if (latch_en) begin
      addr_q  <= bus.Alu_Res;
      data_q  <= bus.D;
      rd_q    <= bus.Rd2;
      rd_en_q <= bus.mem_R;
      wr_en_q <= bus.mem_W;
      wb_q    <= bus.WB;
      regw_q  <= bus.RegW;
    end
  end

  // No reset on the array; gating with rst aborts a store caught mid-access.
  always_ff @(posedge clk) begin
    if (!rst && complete && c_w) begin
      mem[c_idx] <= c_data;
    end
  end

  assign bus.stall        = stall_raw && !rst;
  assign bus.valid_out    = valid_q;
  assign bus.alu_res_out  = alu_q;
  assign bus.mem_data_out = mdata_q;
  assign bus.Rd3          = rd3_q;
  assign bus.WB_out       = wbo_q;
  assign bus.RegW_out     = regwo_q;
  assign bus.misaligned   = mis_q;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: self-checking bench for memory_cycle. Three instances share clk/rst
// (MEM_LAT = 2, 3 and 1, DEPTH = 256); each transaction's expected MEM/WB result, stall
// count and memory effect come from a word-array reference model.
module tb_memory_cycle;
  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [4:0]  rd;
    logic        wb;
    logic        regw;
    logic        mis;
  } out_t;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        r;
    logic        w;
    logic        wb;
    logic        regw;
  } in_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat_of [3] = '{2, 3, 1};
  logic [31:0] ref_mem [3][256];

  memory_cycle_if bus0 ();
  memory_cycle_if bus1 ();
  memory_cycle_if bus2 ();

  memory_cycle #(.DEPTH(256), .MEM_LAT(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  memory_cycle #(.DEPTH(256), .MEM_LAT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  memory_cycle #(.DEPTH(256), .MEM_LAT(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic in_t mk(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                             input logic r, input logic w, input logic wb, input logic regw);
    in_t x;
    x.v = 1'b1; x.a = a; x.d = d; x.rd = rd; x.r = r; x.w = w; x.wb = wb; x.regw = regw;
    return x;
  endfunction

  function automatic in_t rnd_in();
    return mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom));
  endfunction

  task automatic set_in(input int dut, input in_t x);
    case (dut)
      0: {bus0.valid_in, bus0.Alu_Res, bus0.D, bus0.Rd2, bus0.mem_R, bus0.mem_W, bus0.WB,
          bus0.RegW} = x;
      1: {bus1.valid_in, bus1.Alu_Res, bus1.D, bus1.Rd2, bus1.mem_R, bus1.mem_W, bus1.WB,
          bus1.RegW} = x;
      default: {bus2.valid_in, bus2.Alu_Res, bus2.D, bus2.Rd2, bus2.mem_R, bus2.mem_W, bus2.WB,
          bus2.RegW} = x;
    endcase
  endtask

  function automatic out_t get_out(input int dut);
    case (dut)
      0: return {bus0.stall, bus0.valid_out, bus0.alu_res_out, bus0.mem_data_out, bus0.Rd3,
                 bus0.WB_out, bus0.RegW_out, bus0.misaligned};
      1: return {bus1.stall, bus1.valid_out, bus1.alu_res_out, bus1.mem_data_out, bus1.Rd3,
                 bus1.WB_out, bus1.RegW_out, bus1.misaligned};
      default: return {bus2.stall, bus2.valid_out, bus2.alu_res_out, bus2.mem_data_out,
                       bus2.Rd3, bus2.WB_out, bus2.RegW_out, bus2.misaligned};
    endcase
  endfunction

  // Reference: what the retired instruction must look like, how many stall cycles it
  // costs, and its effect on the word array.
  function automatic void model_op(input int dut, input in_t x, output out_t e, output int est);
    int unsigned idx = (x.a / 4) % 256;
    bit mem_op = x.r || x.w;
    bit mis    = mem_op && (x.a % 4 != 0);
    bit acc    = mem_op && !mis;
    est     = acc ? lat_of[dut] - 1 : 0;
    e       = '0;
    e.valid = 1'b1;
    e.alu   = x.a;
    e.rd    = x.rd;
    e.wb    = x.wb;
    e.regw  = mis ? 1'b0 : x.regw;
    e.mis   = mis;
    if (acc && x.r && !x.w) e.mdata = ref_mem[dut][idx];
    if (acc && x.w) ref_mem[dut][idx] = x.d;
  endfunction

  // Holds x until the stage stops stalling, then returns the MEM/WB snapshot after the
  // advancing edge. stalls = -1 when the cycle budget runs out.
  task automatic run_op(input int dut, input in_t x, output out_t got, output int stalls);
    out_t o;
    stalls = 0;
    set_in(dut, x);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      o = get_out(dut);
      @(posedge clk);
      #1;
      if (!o.stall) begin
        got = get_out(dut);
        got.stall = 1'b0;
        return;
      end
      stalls++;
    end
    stalls = -1;
    got = get_out(dut);
    got.stall = 1'b0;
  endtask

  task automatic idle(input int dut);
    set_in(dut, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t o;
    for (int k = 0; k < 3; k++) set_in(k, rnd_in());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = get_out(k);
      n_cmp++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want 0", k, o);
      end
    end
    for (int k = 0; k < 3; k++) set_in(k, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    in_t x; out_t o, e; int st, est;
    for (int k = 0; k < 3; k++) begin
      x = mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      model_op(k, x, e, est);
      run_op(k, x, o, st);
      n_cmp++;
      if (o !== e || st !== est) begin
        n_fail++;
        $display("FAIL sw dut%0d: got %h/%0d stalls want %h/%0d", k, o, st, e, est);
      end
      x = mk(32'h10, $urandom, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      model_op(k, x, e, est);
      run_op(k, x, o, st);
      n_cmp++;
      if (o !== e || st !== est) begin
        n_fail++;
        $display("FAIL lw dut%0d: got %h/%0d stalls want %h/%0d", k, o, st, e, est);
      end
      n_cmp++;
      if (o.mdata !== 32'hDEADBEEF || o.rd !== 5'd5 || o.regw !== 1'b1) begin
        n_fail++;
        $display("FAIL lw_value dut%0d: got data %h rd %0d regw %b want deadbeef 5 1",
                 k, o.mdata, o.rd, o.regw);
      end
      idle(k);
    end
  endtask

  task automatic test_back_to_back();
    in_t x; out_t o, e; int st, est;
    for (int i = 1; i <= 3; i++) begin
      x = mk(32'(i), $urandom, 5'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom));
      model_op(0, x, e, est);
      run_op(0, x, o, st);
      n_cmp++;
      if (o !== e || st !== est) begin
        n_fail++;
        $display("FAIL alu_b2b[%0d]: got %h/%0d stalls want %h/%0d", i, o, st, e, est);
      end
    end
    idle(0);
  endtask

  task automatic test_misaligned();
    in_t x; out_t o, e; int st, est;
    in_t ops [3];
    ops[0] = mk(32'h13, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    ops[1] = mk(32'h12, 32'h5A5A5A5A, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ops[2] = mk(32'h10, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      x = ops[i];
      model_op(0, x, e, est);
      run_op(0, x, o, st);
      n_cmp++;
      if (o !== e || st !== est) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: got %h/%0d stalls want %h/%0d", i, o, st, e, est);
      end
    end
    n_cmp++;
    if (o.mdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL misaligned_keep: got %h want deadbeef", o.mdata);
    end
    idle(0);
    o = get_out(0);
    n_cmp++;
    if ({o.valid, o.regw, o.wb, o.mis} !== 4'b0) begin
      n_fail++;
      $display("FAIL misaligned_bubble: got v/rw/wb/mis %b want 0000",
               {o.valid, o.regw, o.wb, o.mis});
    end
  endtask

  task automatic test_reset_mid_store();
    in_t x; out_t o, e; int st, est;
    x = mk(32'h20, 32'hAAAA5555, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    model_op(1, x, e, est);
    run_op(1, x, o, st);
    n_cmp++;
    if (o !== e || st !== est) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got %h/%0d stalls want %h/%0d", o, st, e, est);
    end
    // Second store is accepted, then reset lands while it is in BUSY.
    set_in(1, mk(32'h20, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    o = get_out(1);
    n_cmp++;
    if (o.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy_stall: got %b want 1", o.stall);
    end
    rst = 1'b1;
    #1;
    o = get_out(1);
    n_cmp++;
    if (o.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_forces_stall: got %b want 0", o.stall);
    end
    @(posedge clk);
    #1;
    o = get_out(1);
    n_cmp++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h want 0", o);
    end
    for (int k = 0; k < 3; k++) set_in(k, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    x = mk(32'h20, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    model_op(1, x, e, est);
    run_op(1, x, o, st);
    n_cmp++;
    if (o !== e || st !== est || o.mdata !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL rst_mid_load: got %h/%0d stalls want %h/%0d data aaaa5555", o, st, e, est);
    end
    idle(1);
  endtask

  task automatic test_wrap();
    in_t x; out_t o, e; int st, est;
    for (int k = 0; k < 3; k++) begin
      x = mk(32'h400, 32'h0000CAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      model_op(k, x, e, est);
      run_op(k, x, o, st);
      x = mk(32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      model_op(k, x, e, est);
      run_op(k, x, o, st);
      n_cmp++;
      if (o !== e || st !== est || o.mdata !== 32'h0000CAFE) begin
        n_fail++;
        $display("FAIL wrap dut%0d: got %h/%0d stalls want %h/%0d data cafe", k, o, st, e, est);
      end
      idle(k);
    end
  endtask

  task automatic test_random();
    in_t x; out_t o, e; int st, est;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        x = mk(($urandom & 32'hFFFF_FC00) | 32'(i << 2), $urandom, 5'($urandom), 1'b0, 1'b1,
               1'($urandom), 1'($urandom));
        model_op(k, x, e, est);
        run_op(k, x, o, st);
        n_cmp++;
        if (o !== e || st !== est) begin
          n_fail++;
          $display("FAIL rnd_fill dut%0d[%0d]: got %h/%0d want %h/%0d", k, i, o, st, e, est);
        end
      end
      for (int i = 0; i < 50; i++) begin
        int kind = $urandom_range(0, 5);
        logic [31:0] aa = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2);
        x = rnd_in();
        case (kind)
          0: begin x.r = 1'b0; x.w = 1'b0; end
          1: begin x.a = aa; x.r = 1'b0; x.w = 1'b1; end
          2: begin x.a = aa; x.r = 1'b1; x.w = 1'b0; end
          3: begin x.a = aa; x.r = 1'b1; x.w = 1'b1; end
          4: begin
            x.a = aa | 32'($urandom_range(1, 3));
            if (!x.r && !x.w) x.r = 1'b1;
          end
          default: x.v = 1'b0;
        endcase
        if (x.v) begin
          model_op(k, x, e, est);
          run_op(k, x, o, st);
          n_cmp++;
          if (o !== e || st !== est) begin
            n_fail++;
            $display("FAIL rnd dut%0d[%0d]: got %h/%0d want %h/%0d", k, i, o, st, e, est);
          end
        end else begin
          set_in(k, x);
          @(posedge clk);
          #1;
          o = get_out(k);
          n_cmp++;
          if ({o.valid, o.regw, o.wb, o.mis} !== 4'b0) begin
            n_fail++;
            $display("FAIL rnd_bubble dut%0d[%0d]: got %b want 0000", k, i,
                     {o.valid, o.regw, o.wb, o.mis});
          end
        end
      end
      idle(k);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) set_in(k, '0);
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
